// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, controller states and a two's-complement magnitude helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Works on a 64-bit container; callers truncate back to XLEN bits.
    function automatic logic [63:0] twos_mag(input logic [63:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift register for the multiply (shift-add) and divide (restoring
// shift-subtract) iterations; one iteration per step pulse.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [XLEN-1:0]     lo_init,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc
);

    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_next;

    assign hi = acc[2*XLEN-1:XLEN];
    assign lo = acc[XLEN-1:0];

    // Multiply: hi holds the partial product, lo the remaining multiplier bits.
    // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        addend    = lo[0] ? opnd_q : {XLEN{1'b0}};
        mul_sum   = {1'b0, hi} + {1'b0, addend};
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_next  = {mul_sum, lo[XLEN-1:1]};
        if (is_div) begin
            if (div_diff[XLEN])
                acc_next = {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            else
                acc_next = {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc    <= {{XLEN{1'b0}}, lo_init};
            opnd_q <= opnd;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/ready accept, XLEN-cycle CALC,
// sign FIX, one-cycle o_valid pulse in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              done_q;

    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_result;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    assign accept  = i_start & o_ready & ~i_flush & (state == IDLE);
    assign o_valid = done_q & ~i_flush;

    always_comb begin
        a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
        b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        a_neg    = a_signed & i_rs1[XLEN-1];
        b_neg    = b_signed & i_rs2[XLEN-1];
        a_mag    = XLEN'(twos_mag(64'(i_rs1), a_neg));
        b_mag    = XLEN'(twos_mag(64'(i_rs2), b_neg));
        div_zero = i_op[2] && (i_rs2 == '0);
        div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
        special_result = '0;
        if (div_zero)
            special_result = i_op[1] ? i_rs1 : '1;
        else if (div_ovf)
            special_result = i_op[1] ? '0 : i_rs1;
    end

    // Sign correction applied once the magnitude iterations have finished.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        quot = (a_neg_q ^ b_neg_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                  fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:         fix_result = quot;
            default:                 fix_result = rem;
        endcase
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk     (i_clk),
        .reset   (i_reset),
        .load    (accept),
        .step    ((state == CALC) & ~i_flush),
        .is_div  (op_q[2]),
        .lo_init (i_op[2] ? a_mag : b_mag),
        .opnd    (i_op[2] ? b_mag : a_mag),
        .acc     (acc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            done_q   <= 1'b0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q    <= i_op;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        count   <= '0;
                        o_ready <= 1'b0;
                        if (div_zero || div_ovf) begin
                            o_result <= special_result;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            o_busy <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (count == LAST_ITER)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (i_flush) begin
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        o_result <= fix_result;
                        o_busy   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit (XLEN=32) against an
// arithmetic reference model.
module tb_muldiv_unit;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Caller is just after a falling edge; returns at the falling edge of the o_valid cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        check("ready_at_start", o_ready, 1);
        i_start = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        @(negedge i_clk);
        i_start = 1'b0;
        i_rs1   = $urandom;
        i_rs2   = $urandom;
        lat     = 1;
        while (!o_valid && lat < 100) begin
            i_start = ($urandom_range(0, 7) == 0);
            i_op    = 3'($urandom_range(0, 7));
            @(negedge i_clk);
            lat++;
            i_rs1 = $urandom;
        end
        i_start = 1'b0;
        check("valid_seen", o_valid, 1);
        res = o_result;
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        run_op(op, a, b, res, lat);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, lat, exp_lat);
        @(negedge i_clk);
        check({tag, "_single_pulse"}, o_valid, 0);
        check({tag, "_ready_after"}, o_ready, 1);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] prior;
        int          lat;
        logic        saw_valid;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_op    = '0;
        i_rs1   = '0;
        i_rs2   = '0;
        i_flush = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_ready", o_ready, 1);
        check("reset_busy", o_busy, 0);
        check("reset_valid", o_valid, 0);
        check("reset_result", o_result, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        directed("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        directed("mul_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 34);
        directed("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        directed("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        directed("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        directed("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        directed("divu_100", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        directed("remu_100", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        directed("div_zero", 3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        directed("rem_zero", 3'd6, 32'h1234, 32'd0, 32'h0000_1234, 1);
        directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Ignored start during CALC, then flush at cycle 10.
        prior = o_result;
        saw_valid = 1'b0;
        check("flush_ready_at_start", o_ready, 1);
        i_start = 1'b1; i_op = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            saw_valid |= o_valid;
            if (c == 3) begin
                check("calc_ready_low", o_ready, 0);
                check("calc_busy_high", o_busy, 1);
                i_start = 1'b1; i_op = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd5;
            end
        end
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        saw_valid |= o_valid;
        check("flush_no_valid", saw_valid, 0);
        check("flush_ready", o_ready, 1);
        check("flush_busy", o_busy, 0);
        check("flush_result_kept", o_result, prior);
        directed("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 34);

        // Flush together with start in IDLE: no accept.
        i_start = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd3;
        @(negedge i_clk);
        i_start = 1'b0; i_flush = 1'b0;
        check("idle_flush_ready", o_ready, 1);
        check("idle_flush_busy", o_busy, 0);
        @(negedge i_clk);
        check("idle_flush_no_valid", o_valid, 0);

        // Flush during DONE suppresses the pulse.
        i_start = 1'b1; i_op = 3'd7; i_rs1 = 32'h55; i_rs2 = 32'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        i_flush = 1'b1;
        #1;
        check("done_flush_valid", o_valid, 0);
        @(negedge i_clk);
        i_flush = 1'b0;
        check("done_flush_ready", o_ready, 1);

        // Reset at cycle 20 of a divide.
        check("reset_pre_result_nonzero", (o_result != 0), 1);
        i_start = 1'b1; i_op = 3'd4; i_rs1 = 32'd12345; i_rs2 = 32'd17;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("midop_reset_ready", o_ready, 1);
        check("midop_reset_result", o_result, 0);
        check("midop_reset_valid", o_valid, 0);
        check("midop_reset_busy", o_busy, 0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            saw_valid |= o_valid;
        end
        check("midop_reset_no_late_valid", saw_valid, 0);

        // Back-to-back randomized operations.
        for (int n = 0; n < 1000; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, res, lat);
            check($sformatf("rand%0d_op%0d_result", n, op), res, ref_model(op, a, b));
            check($sformatf("rand%0d_op%0d_latency", n, op), lat, ref_latency(op, a, b));
            @(negedge i_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the next-generation core.
- Sits beside the ALU in the execute path.
- The core issues an operation through a start/ready handshake and stalls PC/regfile write-back until o_valid.
- The result is written back through an additional write-back mux input.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 8..64, even.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request; accepted only when o_ready=1.
- i_op  in  3  operation, RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  in  XLEN  operand A (multiplicand/dividend).
- i_rs2  in  XLEN  operand B (multiplier/divisor).
- i_flush  in  1  abort the in-flight operation.
- o_ready  out  1  high in IDLE.
- o_busy  out  1  high in CALC and FIX.
- o_valid  out  1  one-cycle pulse; o_result is valid in that cycle.
- o_result  out  XLEN  result; held until the next accepted start.

Behaviour:
- Reset: state=IDLE, o_ready=1, o_busy=0, o_valid=0, o_result=0, counter=0. Reset has priority over everything, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- Accept = i_start & o_ready. On accept, latch i_op and operand magnitudes. Sign-convert: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; MUL, MULHU, DIVU and REMU treat both as unsigned (MUL low half is sign-agnostic). Latch the result sign.
- IDLE -> CALC on accept (normal case).
- IDLE -> DONE directly on accept in these special cases:
  - divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1): DIV result = rs1, REM result = 0.
- CALC: exactly XLEN iterations, one per cycle.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, quotient and remainder each XLEN bits.
  - After the XLEN-th iteration go to FIX.
- FIX: apply sign.
  - Multiply: negate the 2*XLEN product if sign flagged.
  - Quotient: negated if operand signs differ.
  - Remainder: takes the dividend's sign.
  - Select the low half (MUL) or high half (MULH*), quotient or remainder. Register into o_result. Go to DONE.
- DONE: o_valid=1 for exactly this cycle, o_busy=0, o_ready=0. Next cycle -> IDLE.
- Latency (accept cycle = 0):
  - normal: o_valid in cycle XLEN+2 (34 for XLEN=32).
  - special cases: o_valid in cycle 1.
  - Back-to-back: the next start can be accepted the cycle after o_valid.
- i_start while not ready is ignored; no queuing.
- i_flush in CALC/FIX: return to IDLE next cycle, no o_valid, o_result unchanged.
- i_flush in IDLE with i_start: flush wins, no accept.
- i_flush in DONE: the o_valid pulse is suppressed.
- Operand inputs are don't-care after the accept cycle.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding localparams OP_MUL..OP_REMU.
  - state enum typedef (IDLE/CALC/FIX/DONE).
  - helper function for two's-complement magnitude.
- One sub-module: muldiv_datapath, holding the shared accumulator/remainder shift register and add/subtract step, driven by the FSM in muldiv_unit.
- Integrate in the core via an extended wb_sel and a stall on o_busy.

Test Plan (XLEN=32):
- MULH 0x80000000 * 0x80000000 -> o_result=0x40000000; MUL same operands -> 0x00000000; o_valid exactly at cycle 34, single pulse.
- MULHSU 0xFFFFFFFF(-1) * 0xFFFFFFFF(unsigned) -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9(-7) / 2 -> 0xFFFFFFFD(-3); REM same -> 0xFFFFFFFF(-1); DIVU 100/7 -> 14; REMU -> 2.
- DIV by 0 of 0x1234 -> 0xFFFFFFFF; REM by 0 -> 0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; all with o_valid at cycle 1.
- Assert i_start during CALC -> ignored, o_ready=0. Then i_flush at cycle 10 -> IDLE at cycle 11, no o_valid, o_result keeps its prior value. New start accepted at cycle 11.
- i_reset at cycle 20 of a divide -> next cycle o_ready=1, o_result=0, no o_valid. Back-to-back random ops (≥1000) vs reference model, honoring the handshake.
